// File: rtl/temp_sensor_ctrl_pkg.sv
// Shared definitions for the temperature-sensor peripheral: bus map, status bits
// and controller state encoding.
package temp_sensor_ctrl_pkg;

    localparam logic [31:0] TEMP_BASE_ADDR = 32'h7004_0000;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_DATA   = 4'h4;
    localparam logic [3:0] OFF_THRESH = 4'h8;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_VALID = 1;
    localparam int STAT_ALARM = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } temp_state_t;

endpackage

// File: rtl/temp_sclk_gen.sv
// Serial clock generator: divider down-counter with terminal-count compare,
// producing the sclk level, a rise strobe and an end-of-low-phase strobe.
module temp_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    input  logic rise_en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic end_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt_q;
    logic          sclk_q;
    logic          tc;

    assign tc     = run_i && (div_cnt_q == '0);
    // Strobes describe what the coming clk edge does to sclk.
    assign end_o  = tc && !sclk_q;
    assign rise_o = tc && !sclk_q && rise_en_i;
    assign sclk_o = sclk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else if (clear_i) begin
            div_cnt_q <= CW'(CLK_DIV - 1);
            sclk_q    <= 1'b0;
        end else if (run_i) begin
            if (tc) begin
                div_cnt_q <= CW'(CLK_DIV - 1);
                if (sclk_q)
                    sclk_q <= 1'b0;
                else if (rise_en_i)
                    sclk_q <= 1'b1;
            end else begin
                div_cnt_q <= div_cnt_q - CW'(1);
            end
        end else begin
            sclk_q <= 1'b0;
        end
    end

endmodule

// File: rtl/temp_sensor_ctrl.sv
// Memory-mapped temperature-sensor controller: CTRL/STATUS, DATA, THRESH registers
// and the frame sequencer for a 3-wire serial ADC.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no conversion; cs_n high, waiting for a start write
//   ST_SETUP | cs_n low, sclk held low for one half-period before bit 1
//   ST_SHIFT | FRAME_BITS sclk periods, sdo sampled on each rising edge
//   ST_DONE  | one cycle: latch sample, set valid/alarm, pulse done_o
module temp_sensor_ctrl
    import temp_sensor_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        adc_cs_n_o,
    output logic        adc_sclk_o,
    input  logic        adc_sdo_i,
    output logic        done_o
);

    localparam int BW = $clog2(FRAME_BITS + 1);

    temp_state_t           state_q, state_d;
    logic [BW-1:0]         bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0]  data_q;
    logic [DATA_BITS-1:0]  thresh_q;
    logic                  valid_q;
    logic                  alarm_q;
    logic                  cs_n_q;

    logic wr, start_acc, thresh_wr;
    logic sclk_run, rise_en, sclk_rise, sclk_end;
    logic unused_ok;

    assign wr        = req_i && we_i;
    assign start_acc = wr && (addr_i[3:0] == OFF_CTRL) && data_i[0] && (state_q == ST_IDLE);
    assign thresh_wr = wr && (addr_i[3:0] == OFF_THRESH);
    assign unused_ok = &{1'b0, addr_i[31:4], data_i[31:DATA_BITS], shift_q[FRAME_BITS-1:DATA_BITS]};

    temp_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (start_acc),
        .run_i     (sclk_run),
        .rise_en_i (rise_en),
        .sclk_o    (adc_sclk_o),
        .rise_o    (sclk_rise),
        .end_o     (sclk_end)
    );

    always_comb begin
        state_d  = state_q;
        sclk_run = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
        // No further rising edge once every frame bit has been clocked in.
        rise_en  = (state_q == ST_SETUP) || ((state_q == ST_SHIFT) && (bit_cnt_q != '0));
        case (state_q)
            ST_IDLE:  if (start_acc) state_d = ST_SETUP;
            ST_SETUP: if (sclk_end) state_d = ST_SHIFT;
            ST_SHIFT: if (sclk_end && (bit_cnt_q == '0)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cs_n_q    <= 1'b1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            thresh_q  <= '1;
            valid_q   <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
            if (thresh_wr)
                thresh_q <= data_i[DATA_BITS-1:0];
            if (start_acc) begin
                bit_cnt_q <= BW'(FRAME_BITS);
                shift_q   <= '0;
                valid_q   <= 1'b0;
                alarm_q   <= 1'b0;
            end else if (sclk_rise) begin
                bit_cnt_q <= bit_cnt_q - BW'(1);
                shift_q   <= {shift_q[FRAME_BITS-2:0], adc_sdo_i};
            end
            // Compare uses the threshold held during DONE, not a same-cycle write.
            if (state_q == ST_DONE) begin
                data_q  <= shift_q[DATA_BITS-1:0];
                valid_q <= 1'b1;
                alarm_q <= (shift_q[DATA_BITS-1:0] >= thresh_q);
            end
        end
    end

    assign adc_cs_n_o = cs_n_q;
    assign done_o     = (state_q == ST_DONE);

    always_comb begin
        data_o = '0;
        case (addr_i[3:0])
            OFF_CTRL: begin
                data_o[STAT_BUSY]  = (state_q != ST_IDLE);
                data_o[STAT_VALID] = valid_q;
                data_o[STAT_ALARM] = alarm_q;
            end
            OFF_DATA:   data_o[DATA_BITS-1:0] = data_q;
            OFF_THRESH: data_o[DATA_BITS-1:0] = thresh_q;
            default:    data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_temp_sensor_ctrl.sv
// Bench for temp_sensor_ctrl: two instances (CLK_DIV=4 and CLK_DIV=1), a serial
// sensor model per instance, and an abstract register/timing reference model.
module tb_temp_sensor_ctrl;
    import temp_sensor_ctrl_pkg::*;

    localparam int FRAME = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata [2];
    logic [1:0]  cs_n, sclk, sdo, done;
    logic [15:0] frame [2];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int divs [2] = '{4, 1};

    logic [11:0] m_data [2];
    logic [11:0] m_thresh [2];
    logic        m_valid [2];
    logic        m_alarm [2];

    int rises_a [2], ndone_a [2], done_at_a [2], cslow_a [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    temp_sensor_ctrl #(.CLK_DIV(4), .FRAME_BITS(16), .DATA_BITS(12)) u_dut0 (
        .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we), .addr_i(addr), .data_i(wdata),
        .data_o(rdata[0]), .adc_cs_n_o(cs_n[0]), .adc_sclk_o(sclk[0]), .adc_sdo_i(sdo[0]),
        .done_o(done[0])
    );

    temp_sensor_ctrl #(.CLK_DIV(1), .FRAME_BITS(16), .DATA_BITS(12)) u_dut1 (
        .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we), .addr_i(addr), .data_i(wdata),
        .data_o(rdata[1]), .adc_cs_n_o(cs_n[1]), .adc_sclk_o(sclk[1]), .adc_sdo_i(sdo[1]),
        .done_o(done[1])
    );

    // Sensor presents frame MSB first after cs_n falls, advancing after each sclk fall.
    for (genvar g = 0; g < 2; g++) begin : g_sens
        int falls = 0;
        int base = 0;
        int rises = 0;
        int ndone = 0;
        int done_at = -1;
        int cs_low = 0;
        int idx;
        always @(negedge sclk[g]) falls = falls + 1;
        always @(negedge cs_n[g]) base = falls;
        always @(posedge sclk[g]) rises = rises + 1;
        always @(negedge clk) begin
            if (done[g]) begin
                ndone = ndone + 1;
                done_at = cyc;
            end
            if (!cs_n[g]) cs_low = cs_low + 1;
        end
        assign idx       = falls - base;
        assign sdo[g]    = (idx >= 0 && idx < FRAME) ? frame[g][FRAME-1-idx] : 1'b0;
        assign rises_a[g]   = rises;
        assign ndone_a[g]   = ndone;
        assign done_at_a[g] = done_at;
        assign cslow_a[g]   = cs_low;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic bus_wr(input int sel, input logic [3:0] off, input logic [31:0] d);
        req[sel] = 1'b1;
        we       = 1'b1;
        addr     = TEMP_BASE_ADDR | {28'h0, off};
        wdata    = d;
        tick();
        req[sel] = 1'b0;
        we       = 1'b0;
    endtask

    task automatic bus_rd(input int sel, input logic [3:0] off, output logic [31:0] d);
        we   = 1'b0;
        addr = TEMP_BASE_ADDR | {28'h0, off};
        #1;
        d = rdata[sel];
    endtask

    function automatic logic [31:0] exp_stat(input int sel);
        return {29'd0, m_alarm[sel], m_valid[sel], 1'b0};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_data[s]   = 12'h000;
            m_thresh[s] = 12'hFFF;
            m_valid[s]  = 1'b0;
            m_alarm[s]  = 1'b0;
        end
    endtask

    // Full conversion driven like the core: start, poll STATUS until idle, read DATA.
    // mid_off < 0 means no extra bus write during the frame.
    task automatic run_conv(input int sel, input logic [15:0] frm, input int mid_off,
                            input logic [3:0] mid_off_reg, input logic [31:0] mid_data);
        int t, d_off, n_r, n_d, n_cs, t_exit;
        logic [31:0] v;
        logic [11:0] thr_done, sample;
        frame[sel] = frm;
        d_off = 1 + (2 * FRAME + 1) * divs[sel];
        n_r  = rises_a[sel];
        n_d  = ndone_a[sel];
        n_cs = cslow_a[sel];
        thr_done = m_thresh[sel];
        t = cyc;
        bus_wr(sel, OFF_CTRL, 32'h1);
        m_valid[sel] = 1'b0;
        m_alarm[sel] = 1'b0;
        bus_rd(sel, OFF_CTRL, v);
        chk("busy_after_start", v, 32'h1);
        t_exit = -1;
        for (int k = 0; k < 400; k++) begin
            if (cyc == t + mid_off) begin
                bus_wr(sel, mid_off_reg, mid_data);
                if (mid_off_reg == OFF_THRESH) begin
                    m_thresh[sel] = mid_data[11:0];
                    if (mid_off < d_off) thr_done = mid_data[11:0];
                end
            end else begin
                bus_rd(sel, OFF_CTRL, v);
                if (v[0] == 1'b0) begin
                    t_exit = cyc;
                    break;
                end
                tick();
            end
        end
        sample       = frm[11:0];
        m_data[sel]  = sample;
        m_valid[sel] = 1'b1;
        m_alarm[sel] = (sample >= thr_done);
        chk("poll_exit_cycle", 32'(t_exit - t), 32'(d_off + 1));
        chk("done_cycle", 32'(done_at_a[sel] - t), 32'(d_off));
        chk("done_pulses", 32'(ndone_a[sel] - n_d), 32'd1);
        chk("sclk_rises", 32'(rises_a[sel] - n_r), 32'(FRAME));
        chk("cs_low_cycles", 32'(cslow_a[sel] - n_cs), 32'(d_off - 1));
        chk("status_after", v, exp_stat(sel));
        bus_rd(sel, OFF_DATA, v);
        chk("data_after", v, {20'd0, m_data[sel]});
        tick();
        tick();
        tick();
        chk("cs_n_idle", {31'd0, cs_n[sel]}, 32'd1);
        bus_rd(sel, OFF_CTRL, v);
        chk("status_sticky", v, exp_stat(sel));
        bus_rd(sel, OFF_THRESH, v);
        chk("thresh_after", v, {20'd0, m_thresh[sel]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [15:0] f;
        logic [11:0] th;
        logic [3:0]  regs [3];
        int t, n_d, mo, pick;
        regs[0] = OFF_CTRL;
        regs[1] = OFF_THRESH;
        regs[2] = OFF_DATA;
        frame[0] = 16'h0;
        frame[1] = 16'h0;
        model_reset();

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cs_n", {31'd0, cs_n[0]}, 32'd1);
        chk("rst_sclk", {31'd0, sclk[0]}, 32'd0);
        chk("rst_done", {31'd0, done[0]}, 32'd0);
        bus_rd(0, OFF_CTRL, v);   chk("rst_status", v, 32'h0);
        bus_rd(0, OFF_DATA, v);   chk("rst_data", v, 32'h0);
        bus_rd(0, OFF_THRESH, v); chk("rst_thresh", v, 32'hFFF);
        tick();

        bus_wr(0, OFF_CTRL, 32'hFFFF_FFFE);
        bus_rd(0, OFF_CTRL, v);   chk("start_bit0_clear", v, 32'h0);
        chk("no_start_cs_n", {31'd0, cs_n[0]}, 32'd1);
        bus_wr(0, OFF_DATA, 32'h0000_0555);
        bus_rd(0, OFF_DATA, v);   chk("data_write_ignored", v, 32'h0);
        bus_wr(0, OFF_THRESH, 32'hFFFF_F123);
        m_thresh[0] = 12'h123;
        bus_rd(0, OFF_THRESH, v); chk("thresh_masked", v, 32'h123);
        bus_rd(0, 4'hC, v);       chk("unmapped_read", v, 32'h0);
        req[0] = 1'b1; we = 1'b0; addr = TEMP_BASE_ADDR; wdata = 32'h1;
        tick();
        req[0] = 1'b0;
        chk("read_strobe_no_start", {31'd0, cs_n[0]}, 32'd1);

        bus_wr(0, OFF_THRESH, 32'hFFF);
        m_thresh[0] = 12'hFFF;
        run_conv(0, 16'h0ABC, -1, OFF_CTRL, 32'h0);

        bus_wr(0, OFF_THRESH, 32'h800);
        m_thresh[0] = 12'h800;
        run_conv(0, 16'hF800, -1, OFF_CTRL, 32'h0);
        bus_wr(0, OFF_THRESH, 32'h801);
        m_thresh[0] = 12'h801;
        run_conv(0, 16'hF800, -1, OFF_CTRL, 32'h0);

        run_conv(0, 16'h5A5A, 50, OFF_CTRL, 32'h1);
        run_conv(0, 16'h1234, 133, OFF_CTRL, 32'h1);
        run_conv(0, 16'h0FFF, 133, OFF_THRESH, 32'h0);
        run_conv(0, 16'h0555, 70, OFF_THRESH, 32'h400);

        f = 16'($urandom);
        frame[0] = f;
        t = cyc;
        bus_wr(0, OFF_CTRL, 32'h1);
        while (cyc < t + 60) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        n_d = ndone_a[0];
        chk("midrst_cs_n", {31'd0, cs_n[0]}, 32'd1);
        chk("midrst_sclk", {31'd0, sclk[0]}, 32'd0);
        bus_rd(0, OFF_CTRL, v);   chk("midrst_status", v, 32'h0);
        for (int k = 0; k < 150; k++) tick();
        chk("midrst_no_done", 32'(ndone_a[0] - n_d), 32'd0);
        bus_rd(0, OFF_DATA, v);   chk("midrst_data", v, 32'h0);
        run_conv(0, 16'($urandom), -1, OFF_CTRL, 32'h0);

        for (int n = 0; n < 6; n++) begin
            f  = 16'($urandom);
            th = ($urandom_range(0, 1) == 1) ? f[11:0] : 12'($urandom);
            bus_wr(0, OFF_THRESH, {20'd0, th});
            m_thresh[0] = th;
            pick = $urandom_range(0, 3);
            mo = (pick == 3) ? -1 : $urandom_range(2, 133);
            run_conv(0, f, mo, regs[pick % 3], $urandom);
        end

        run_conv(1, 16'h0ABC, -1, OFF_CTRL, 32'h0);
        for (int n = 0; n < 3; n++) begin
            f  = 16'($urandom);
            th = 12'($urandom);
            bus_wr(1, OFF_THRESH, {20'd0, th});
            m_thresh[1] = th;
            run_conv(1, f, $urandom_range(2, 34), OFF_THRESH, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
